// File: rtl/cinit_seq_gen_if.sv
// Request/result bundle between a c_init consumer (master) and cinit_seq_gen (slave).
// Carries the start request, the cell/slot operands and the valid/ready result stream.
interface cinit_seq_gen_if #(
  parameter int ID_W   = 9,
  parameter int SLOT_W = 5
);
  logic              start;
  logic [ID_W-1:0]   N_cell_ID;
  logic [SLOT_W-1:0] slot;
  logic              busy;
  logic [27:0]       cinit;
  logic [2:0]        sym_l;
  logic              last;
  logic              valid;
  logic              ready;
  logic              err;

  modport master (
    output start, N_cell_ID, slot, ready,
    input  busy, cinit, sym_l, last, valid, err
  );

  modport slave (
    input  start, N_cell_ID, slot, ready,
    output busy, cinit, sym_l, last, valid, err
  );
endinterface

// File: rtl/cinit_seq_gen.sv
// NRS c_init generator: one request yields N_SYM results of 2^10*A*B + 2*ID + N_CP,
// with A*B formed by an iterative shift-add multiplier and streamed out over valid/ready.
module cinit_seq_gen #(
  parameter int ID_W     = 9,
  parameter int ID_MAX   = 503,
  parameter int SLOT_W   = 5,
  parameter int N_SYM    = 2,
  parameter int L_FIRST  = 5,
  parameter int N_CP     = 1,
  parameter int MUL_STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  cinit_seq_gen_if.slave bus
);

  localparam int                M         = 8 / MUL_STEP;
  localparam logic [2:0]        STEP_LAST = 3'(M - 1);
  localparam logic [ID_W-1:0]   ID_LIM    = ID_W'(ID_MAX);
  localparam logic [SLOT_W-1:0] SLOT_LIM  = SLOT_W'(19);
  // 7*(ns+1) + l + 1 with l = L_FIRST + sym folds into 7*ns + sym + (L_FIRST + 8)
  localparam logic [7:0]        A_OFS     = 8'(L_FIRST + 8);
  localparam logic [2:0]        L_BASE    = 3'(L_FIRST);
  localparam logic [2:0]        SYM_LAST  = 3'(N_SYM - 1);
  localparam logic              N_CP_BIT  = 1'(N_CP);

  typedef enum logic [1:0] {IDLE, LOAD, MUL, OUT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q,    id_d;
  logic [SLOT_W-1:0] slot_q,  slot_d;
  logic [2:0]        sym_q,   sym_d;
  logic [2:0]        step_q,  step_d;
  logic [7:0]        a_q,     a_d;
  logic [17:0]       mcand_q, mcand_d;
  logic [17:0]       acc_q,   acc_d;
  logic [27:0]       cinit_q, cinit_d;
  logic [2:0]        sym_l_q, sym_l_d;
  logic              last_q,  last_d;
  logic              err_q,   err_d;
  logic [17:0]       acc_sum;

  // NOTE: synchronous reset is evaluated inside the clocked block, and every flop uses <=
  // so all of them sample pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      slot_q  <= '0;
      sym_q   <= '0;
      step_q  <= '0;
      a_q     <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cinit_q <= '0;
      sym_l_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      slot_q  <= slot_d;
      sym_q   <= sym_d;
      step_q  <= step_d;
      a_q     <= a_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cinit_q <= cinit_d;
      sym_l_q <= sym_l_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q (err from 0) so no branch leaves a latch behind.
    state_d = state_q;
    id_d    = id_q;
    slot_d  = slot_q;
    sym_d   = sym_q;
    step_d  = step_q;
    a_d     = a_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cinit_d = cinit_q;
    sym_l_d = sym_l_q;
    last_d  = last_q;
    err_d   = 1'b0;
    acc_sum = acc_q + mcand_q * 18'(a_q[MUL_STEP-1:0]);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          id_d   = bus.N_cell_ID;
          slot_d = bus.slot;
          sym_d  = '0;
          if (bus.N_cell_ID > ID_LIM || bus.slot > SLOT_LIM) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        a_d     = 8'(slot_q) * 8'd7 + A_OFS + 8'(sym_q);
        mcand_d = 18'({id_q, 1'b1});
        acc_d   = '0;
        step_d  = '0;
        state_d = MUL;
      end
      MUL: begin
        // multiplicand moves left as A moves right, so no explicit bit-position shifter
        acc_d   = acc_sum;
        a_d     = a_q >> MUL_STEP;
        mcand_d = mcand_q << MUL_STEP;
        step_d  = step_q + 3'd1;
        if (step_q == STEP_LAST) begin
          // low field 2*ID+N_CP < 1024, so concatenation equals the addition
          cinit_d = {acc_sum, id_q, N_CP_BIT};
          sym_l_d = L_BASE + sym_q;
          last_d  = (sym_q == SYM_LAST);
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            sym_d   = sym_q + 3'd1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.valid = (state_q == OUT);
    bus.cinit = cinit_q;
    bus.sym_l = sym_l_q;
    bus.last  = last_q;
    bus.err   = err_q;
  end

endmodule

// File: tb/tb_cinit_seq_gen.sv
// Bench for cinit_seq_gen: four instances (MUL_STEP 1/2/4/8) share stimulus; a per-instance
// transaction model predicts busy/valid/err and each result, plus literal expectations.
module tb_cinit_seq_gen;

  localparam int NI      = 4;
  localparam int N_SYM   = 2;
  localparam int L_FIRST = 5;
  localparam int N_CP    = 1;
  localparam int LAT [NI] = '{10, 6, 4, 3};

  logic       clk;
  logic       rst;
  logic       start;
  logic       ready;
  logic [8:0] id_in;
  logic [4:0] slot_in;
  bit         chk_en;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint c;
    int     l;
    bit     last;
  } exp_t;

  typedef struct packed {
    logic [27:0] c;
    logic [2:0]  l;
    logic        last;
  } log_t;

  logic        busy_v  [NI];
  logic        valid_v [NI];
  logic        err_v   [NI];
  logic        last_v  [NI];
  logic [27:0] cinit_v [NI];
  logic [2:0]  syml_v  [NI];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint cinit_ref(input int id, input int ns, input int l);
    longint a = longint'(7 * (ns + 1) + l + 1);
    longint b = longint'(2 * id + 1);
    return a * b * 1024 + longint'(2 * id + N_CP);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int M = 8 >> g;

    cinit_seq_gen_if bus ();
    cinit_seq_gen #(.MUL_STEP(1 << g)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.start     = start;
    assign bus.N_cell_ID = id_in;
    assign bus.slot      = slot_in;
    assign bus.ready     = ready;
    assign busy_v[g]     = bus.busy;
    assign valid_v[g]    = bus.valid;
    assign err_v[g]      = bus.err;
    assign last_v[g]     = bus.last;
    assign cinit_v[g]    = bus.cinit;
    assign syml_v[g]     = bus.sym_l;

    // pending results of the accepted request; cd = edges left before the head is offered
    exp_t q[$];
    int   cd      = 0;
    bit   exp_err = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        cd      <= 0;
        exp_err <= 1'b0;
      end else begin
        exp_err <= 1'b0;
        if (q.size() != 0) begin
          if (cd > 0) begin
            cd <= cd - 1;
          end else if (ready) begin
            void'(q.pop_front());
            cd <= M + 1;
          end
        end else if (start) begin
          if (id_in > 9'd503 || slot_in > 5'd19) begin
            exp_err <= 1'b1;
          end else begin
            for (int s = 0; s < N_SYM; s++)
              q.push_back('{cinit_ref(int'(id_in), int'(slot_in), L_FIRST + s), L_FIRST + s,
                            bit'(s == N_SYM - 1)});
            cd <= M + 1;
          end
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check($sformatf("u%0d.busy", g),  longint'(bus.busy),  longint'(q.size() != 0));
        check($sformatf("u%0d.valid", g), longint'(bus.valid), longint'(q.size() != 0 && cd == 0));
        check($sformatf("u%0d.err", g),   longint'(bus.err),   longint'(exp_err));
        if (q.size() != 0 && cd == 0) begin
          check($sformatf("u%0d.cinit", g), longint'(bus.cinit), q[0].c);
          check($sformatf("u%0d.sym_l", g), longint'(bus.sym_l), longint'(q[0].l));
          check($sformatf("u%0d.last", g),  longint'(bus.last),  longint'(q[0].last));
        end
      end
    end
  end

  // handshakes of the MUL_STEP=1 instance, pinned against hand-computed values
  log_t log_q[$];
  always @(posedge clk) begin
    if (!rst && valid_v[0] && ready)
      log_q.push_back('{cinit_v[0], syml_v[0], last_v[0]});
  end

  task automatic pulse_start(input int id, input int ns);
    @(negedge clk);
    id_in   = 9'(id);
    slot_in = 5'(ns);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_v[0] | busy_v[1] | busy_v[2] | busy_v[3]) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", longint'(n < 400), 1);
  endtask

  task automatic check_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s.u%0d.busy", tag, g),  longint'(busy_v[g]),  0);
      check($sformatf("%s.u%0d.valid", tag, g), longint'(valid_v[g]), 0);
      check($sformatf("%s.u%0d.err", tag, g),   longint'(err_v[g]),   0);
      check($sformatf("%s.u%0d.last", tag, g),  longint'(last_v[g]),  0);
      check($sformatf("%s.u%0d.cinit", tag, g), longint'(cinit_v[g]), 0);
      check($sformatf("%s.u%0d.sym_l", tag, g), longint'(syml_v[g]),  0);
    end
  endtask

  task automatic expect_log(input int idx, input longint c, input int l, input bit last);
    check($sformatf("log%0d.present", idx), longint'(log_q.size() > idx), 1);
    if (log_q.size() > idx) begin
      check($sformatf("log%0d.cinit", idx), longint'(log_q[idx].c), c);
      check($sformatf("log%0d.sym_l", idx), longint'(log_q[idx].l), longint'(l));
      check($sformatf("log%0d.last", idx),  longint'(log_q[idx].last), longint'(last));
    end
  endtask

  // start, then record for each instance the cycle (accept cycle = 0) where valid first rises
  task automatic run_timed(input int id, input int ns, input string tag);
    int lat [NI];
    for (int g = 0; g < NI; g++) lat[g] = -1;
    pulse_start(id, ns);
    for (int c = 1; c <= 30; c++) begin
      for (int g = 0; g < NI; g++)
        if (lat[g] < 0 && valid_v[g]) lat[g] = c;
      if (c < 30) @(negedge clk);
    end
    for (int g = 0; g < NI; g++)
      check($sformatf("%s.latency.u%0d", tag, g), longint'(lat[g]), longint'(LAT[g]));
    wait_idle();
  endtask

  initial begin
    int base;
    int n;
    rst     = 1'b1;
    start   = 1'b0;
    ready   = 1'b1;
    id_in   = '0;
    slot_in = '0;
    chk_en  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check_zero("reset");
    rst = 1'b0;

    base = log_q.size();
    run_timed(0, 0, "id0");
    expect_log(base,     13313, 5, 1'b0);
    expect_log(base + 1, 14337, 6, 1'b1);

    base = log_q.size();
    run_timed(503, 19, "id503");
    expect_log(base,     150551535, 5, 1'b0);
    expect_log(base + 1, 151582703, 6, 1'b1);

    base = log_q.size();
    run_timed(100, 3, "id100");
    expect_log(base,     6998217, 5, 1'b0);
    expect_log(base + 1, 7204041, 6, 1'b1);

    // backpressure on the first result, with a start and new operands arriving while busy
    base = log_q.size();
    pulse_start(7, 2);
    n = 0;
    while (!valid_v[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp.valid_timeout", longint'(n < 40), 1);
    ready   = 1'b0;
    id_in   = 9'd300;
    slot_in = 5'd4;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    ready = 1'b1;
    wait_idle();
    check("bp.handshakes", longint'(log_q.size() - base), 2);
    expect_log(base,     414735, 5, 1'b0);
    expect_log(base + 1, 430095, 6, 1'b1);

    // illegal operands: one-cycle err, never busy, no result
    base = log_q.size();
    pulse_start(504, 0);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("err_id.u%0d.err", g),  longint'(err_v[g]),  1);
      check($sformatf("err_id.u%0d.busy", g), longint'(busy_v[g]), 0);
    end
    @(negedge clk);
    for (int g = 0; g < NI; g++)
      check($sformatf("err_id.u%0d.err_end", g), longint'(err_v[g]), 0);
    pulse_start(5, 20);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("err_ns.u%0d.err", g),  longint'(err_v[g]),  1);
      check($sformatf("err_ns.u%0d.busy", g), longint'(busy_v[g]), 0);
    end
    repeat (15) @(negedge clk);
    check("err.no_result", longint'(log_q.size() - base), 0);

    // reset during the third multiply cycle of the MUL_STEP=1 instance
    base = log_q.size();
    pulse_start(200, 10);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    rst = 1'b0;
    check("rst.no_result", longint'(log_q.size() - base), 0);

    base = log_q.size();
    pulse_start(0, 0);
    wait_idle();
    expect_log(base,     13313, 5, 1'b0);
    expect_log(base + 1, 14337, 6, 1'b1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
